// File: rtl/psram_ip_pkg.sv
// Shared types and constants for the PSRAM IP responder and the benches
// that drive it through the byte wrapper.
package psram_ip_pkg;

  typedef enum logic [1:0] {
    CALIB,
    IDLE,
    RD_WAIT,
    WR_HOLD
  } state_e;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  localparam int DEF_MEM_AW       = 12;
  localparam int DEF_CALIB_CYCLES = 64;
  localparam int DEF_RD_LATENCY   = 6;
  localparam int DEF_WR_BUSY      = 4;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int DROP_W = 8;
  localparam int CNT_W  = 16;

endpackage

// File: rtl/psram_ip_responder_if.sv
// Command/response bundle of the 32-bit PSRAM controller port.
// master = cart-bus/byte-wrapper side, slave = responder (IP stand-in).
interface psram_ip_responder_if;
  import psram_ip_pkg::*;

  logic              cmd;
  logic              cmd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [MASK_W-1:0] data_mask;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              init_calib;
  logic              cmd_dropped;
  logic [DROP_W-1:0] drop_count;

  modport master (
    output cmd, cmd_en, addr, wr_data, data_mask,
    input  rd_data, rd_data_valid, init_calib, cmd_dropped, drop_count
  );

  modport slave (
    input  cmd, cmd_en, addr, wr_data, data_mask,
    output rd_data, rd_data_valid, init_calib, cmd_dropped, drop_count
  );

endinterface

// File: rtl/psram_model_ram.sv
// Single-port 2^AW x 32 RAM with active-low byte enables and a registered
// read port (read-first). Maps onto block RAM.
module psram_model_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be_n,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];

  // Byte-masked write and registered read of the addressed word
  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // the array has no reset so it maps to BRAM and survives a logic reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!i_be_n[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/psram_ip_responder.sv
// BRAM-backed stand-in for the vendor PSRAM IP: calibration delay, fixed
// read latency, write occupancy, byte masking and a count of commands that
// arrived while the responder could not take them.
module psram_ip_responder
  import psram_ip_pkg::*;
#(
  parameter int MEM_AW       = DEF_MEM_AW,
  parameter int CALIB_CYCLES = DEF_CALIB_CYCLES,
  parameter int RD_LATENCY   = DEF_RD_LATENCY,
  parameter int WR_BUSY      = DEF_WR_BUSY
) (
  input  logic                 clk,
  input  logic                 reset,
  psram_ip_responder_if.slave  bus
);

  state_e              r_state;
  state_e              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [MEM_AW-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_be_n;
  logic                r_wr_pend;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic                r_cmd_dropped;
  logic [DROP_W-1:0]   r_drop_count;
  logic [DATA_W-1:0]   w_ram_q;
  logic                w_accept_rd;
  logic                w_accept_wr;
  logic                w_reject;
  logic                w_rd_done;
  logic                w_init_calib;

  // Address bits above the backing depth alias away by design.
  logic w_unused_addr;
  assign w_unused_addr = ^bus.addr[ADDR_W-1:MEM_AW];

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= CALIB;
    else       r_state <= w_next_state;
  end

  // Next-state logic: each wait state exits on its terminal count
  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      CALIB:   if (r_cnt == CNT_W'(CALIB_CYCLES - 1)) w_next_state = IDLE;
      IDLE:    if (bus.cmd_en) w_next_state = (bus.cmd == CMD_WR) ? WR_HOLD : RD_WAIT;
      RD_WAIT: if (r_cnt == CNT_W'(RD_LATENCY - 1)) w_next_state = IDLE;
      WR_HOLD: if (r_cnt == CNT_W'(WR_BUSY - 1)) w_next_state = IDLE;
      default: w_next_state = CALIB;
    endcase
  end

  // Output decode: command acceptance/rejection and read completion
  always_comb begin
    w_accept_rd  = (r_state == IDLE) && bus.cmd_en && (bus.cmd == CMD_RD);
    w_accept_wr  = (r_state == IDLE) && bus.cmd_en && (bus.cmd == CMD_WR);
    w_reject     = (r_state != IDLE) && bus.cmd_en;
    w_rd_done    = (r_state == RD_WAIT) && (r_cnt == CNT_W'(RD_LATENCY - 1));
    w_init_calib = (r_state != CALIB);
  end

  // Cycle counter for the current state; restarts on every state change
  always_ff @(posedge clk) begin
    if (reset)                                             r_cnt <= '0;
    else if (w_next_state != r_state || r_state == IDLE)   r_cnt <= '0;
    else                                                   r_cnt <= r_cnt + CNT_W'(1);
  end

  // Command capture; these only matter after an accept, so no reset
  always_ff @(posedge clk) begin
    if (w_accept_rd || w_accept_wr) begin
      r_addr  <= bus.addr[MEM_AW-1:0];
      r_wdata <= bus.wr_data;
      r_be_n  <= bus.data_mask;
    end
  end

  // Response and drop bookkeeping; the write commits one edge after accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_pend     <= 1'b0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_cmd_dropped <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      r_wr_pend     <= w_accept_wr;
      r_rd_valid    <= w_rd_done;
      r_cmd_dropped <= w_reject;
      if (w_rd_done) r_rd_data <= w_ram_q;
      if (w_reject && r_drop_count != '1) r_drop_count <= r_drop_count + DROP_W'(1);
    end
  end

  psram_model_ram #(.AW(MEM_AW)) u_ram (
    .clk     (clk),
    .i_we    (r_wr_pend),
    .i_be_n  (r_be_n),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  assign bus.rd_data       = r_rd_data;
  assign bus.rd_data_valid = r_rd_valid;
  assign bus.init_calib    = w_init_calib;
  assign bus.cmd_dropped   = r_cmd_dropped;
  assign bus.drop_count    = r_drop_count;

endmodule

// File: tb/tb_psram_ip_responder.sv
// Directed bench for psram_ip_responder: reads push their expected word and
// valid cycle onto a scoreboard; a negedge monitor pops and compares.
module tb_psram_ip_responder;
  import psram_ip_pkg::*;

  localparam int CALIB  = DEF_CALIB_CYCLES;
  localparam int RD_LAT = DEF_RD_LATENCY;
  localparam int WB     = DEF_WR_BUSY;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_valid = 0;
  int   exp_drop = 0;
  exp_t sb[$];

  psram_ip_responder_if dut_if ();

  psram_ip_responder #(
    .MEM_AW       (DEF_MEM_AW),
    .CALIB_CYCLES (CALIB),
    .RD_LATENCY   (RD_LAT),
    .WR_BUSY      (WB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; outputs are read there too.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One cmd_en pulse; for reads d is the word expected back.
  task automatic issue(input logic c, input logic [20:0] a, input logic [31:0] d,
                       input logic [3:0] m, input bit accept, input string tag);
    dut_if.cmd       = c;
    dut_if.addr      = a;
    dut_if.wr_data   = d;
    dut_if.data_mask = m;
    dut_if.cmd_en    = 1'b1;
    step(1);
    dut_if.cmd_en = 1'b0;
    if (!accept && exp_drop < 255) exp_drop++;
    check({tag, "_dropped"}, dut_if.cmd_dropped, !accept);
    check({tag, "_drop_count"}, dut_if.drop_count, exp_drop);
    if (accept && c == CMD_RD) sb.push_back('{d, cyc + RD_LAT});
  endtask

  task automatic wait_reads(input string tag);
    for (int k = 0; k < RD_LAT + 4 && sb.size() != 0; k++) step(1);
    check({tag, "_drained"}, 32'(sb.size()), 0);
  endtask

  task automatic wait_calib(input int rel, input string tag);
    for (int k = 0; k < 4 * CALIB && dut_if.init_calib !== 1'b1; k++) step(1);
    check(tag, 32'(cyc - rel), 32'(CALIB));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_data"}, dut_if.rd_data, 0);
    check({tag, "_rd_valid"}, dut_if.rd_data_valid, 0);
    check({tag, "_init_calib"}, dut_if.init_calib, 0);
    check({tag, "_dropped"}, dut_if.cmd_dropped, 0);
    check({tag, "_drop_count"}, dut_if.drop_count, 0);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest pending read.
  always @(negedge clk) begin
    if (dut_if.rd_data_valid === 1'b1) begin
      n_valid++;
      check("rd_valid_was_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("rd_data", dut_if.rd_data, e.data);
        check("rd_valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, t, v0;
    reset            = 1'b1;
    dut_if.cmd       = CMD_RD;
    dut_if.cmd_en    = 1'b0;
    dut_if.addr      = '0;
    dut_if.wr_data   = '0;
    dut_if.data_mask = 4'hF;
    step(3);
    check_reset_outputs("por");

    // Calibration: reject during CALIB, init_calib rises in cycle 64
    reset = 1'b0;
    r0    = cyc;
    step(9);
    issue(CMD_RD, 21'h000000, 32'h0, 4'hF, 0, "calib_reject");
    step(1);
    check("dropped_single_pulse", dut_if.cmd_dropped, 0);
    wait_calib(r0, "calib_rise_cycle");

    // Write in the very cycle init_calib rises, then read back at earliest slot
    issue(CMD_WR, 21'h000123, 32'hDEADBEEF, 4'b0000, 1, "wr_first");
    step(WB);
    issue(CMD_RD, 21'h000123, 32'hDEADBEEF, 4'hF, 1, "rd_first");
    wait_reads("rd_first");

    // Byte mask: bytes 0 and 2 written, 1 and 3 kept
    issue(CMD_WR, 21'h000123, 32'h11223344, 4'b1010, 1, "wr_mask");
    step(WB);
    issue(CMD_RD, 21'h000123, 32'hDE22BE44, 4'hF, 1, "rd_mask");
    wait_reads("rd_mask");
    step(2);
    check("rd_data_held", dut_if.rd_data, 32'hDE22BE44);
    check("rd_valid_low_after", dut_if.rd_data_valid, 0);

    // Busy rejection: first and last cycle of WR_HOLD and of RD_WAIT
    v0 = n_valid;
    issue(CMD_WR, 21'h000200, 32'h55555555, 4'b0000, 1, "wr_busy");
    issue(CMD_RD, 21'h000123, 32'h0, 4'hF, 0, "rej_wr_hold_first");
    step(WB - 2);
    issue(CMD_WR, 21'h000200, 32'hAAAAAAAA, 4'b0000, 0, "rej_wr_hold_last");
    issue(CMD_RD, 21'h000200, 32'h55555555, 4'hF, 1, "rd_busy");
    t = cyc;
    issue(CMD_WR, 21'h000200, 32'hAAAAAAAA, 4'b0000, 0, "rej_rd_wait_first");
    step(RD_LAT - 2);
    issue(CMD_RD, 21'h000123, 32'h0, 4'hF, 0, "rej_rd_wait_last");
    check("valid_cycle_reached", 32'(cyc - t), 32'(RD_LAT));
    // The valid cycle already counts as IDLE
    issue(CMD_RD, 21'h000200, 32'h55555555, 4'hF, 1, "rd_in_valid_cycle");
    wait_reads("rd_busy");
    check("valid_pulses_busy", 32'(n_valid - v0), 2);

    // Aliasing modulo 2^MEM_AW
    issue(CMD_WR, 21'h001005, 32'hCAFEF00D, 4'b0000, 1, "wr_alias");
    step(WB);
    issue(CMD_RD, 21'h000005, 32'hCAFEF00D, 4'hF, 1, "rd_alias");
    wait_reads("rd_alias");

    // Saturation: hold a fully masked write strobe; most cycles are rejects
    dut_if.cmd       = CMD_WR;
    dut_if.addr      = 21'h000005;
    dut_if.wr_data   = 32'h0;
    dut_if.data_mask = 4'hF;
    dut_if.cmd_en    = 1'b1;
    step(400);
    dut_if.cmd_en = 1'b0;
    step(WB + 1);
    check("drop_count_saturated", dut_if.drop_count, 8'hFF);
    exp_drop = 255;
    issue(CMD_RD, 21'h000005, 32'hCAFEF00D, 4'hF, 1, "rd_full_mask");
    wait_reads("rd_full_mask");

    // Reset mid-read: pending valid cancelled, memory kept
    issue(CMD_RD, 21'h000123, 32'hDE22BE44, 4'hF, 1, "rd_reset");
    step(2);
    reset = 1'b1;
    sb.delete();
    exp_drop = 0;
    v0 = n_valid;
    step(1);
    check_reset_outputs("mid_read_reset");
    step(1);
    reset = 1'b0;
    r0    = cyc;
    wait_calib(r0, "recalib_rise_cycle");
    check("no_valid_after_reset", 32'(n_valid - v0), 0);
    issue(CMD_RD, 21'h000123, 32'hDE22BE44, 4'hF, 1, "rd_after_reset");
    wait_reads("rd_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
